// File: rtl/lde_gate_sequencer_if.sv
// Write-request / latch-bank bus for lde_gate_sequencer.
// The master side drives REQ/ADDR/DIN. The slave side is the sequencer,
// which drives the handshake, status and latch-bank pins.
interface lde_gate_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4,
    parameter int AW     = 2
);
    logic              REQ;
    logic [AW-1:0]     ADDR;
    logic [WIDTH-1:0]  DIN;
    logic              ACK;
    logic [WIDTH-1:0]  D;
    logic              G;
    logic [NWORDS-1:0] GE;
    logic              BUSY;
    logic              DONE;
    logic              ERR;

    modport master (output REQ, ADDR, DIN,
                    input  ACK, D, G, GE, BUSY, DONE, ERR);
    modport slave  (input  REQ, ADDR, DIN,
                    output ACK, D, G, GE, BUSY, DONE, ERR);
endinterface

// File: rtl/lde_gate_sequencer.sv
// Write sequencer for a bank of NWORDS x WIDTH active-low-gate latches.
// Each accepted write produces a setup / open / hold waveform:
//   - D and GE settle first.
//   - G then goes low for PULSE_CYC cycles.
//   - G closes while D and GE are still held.
// As a result, G edges never coincide with D or GE edges.
// Optional macro LDESEQ_BACK2BACK_EN: accept a new write in FIN so that
// consecutive writes run with no IDLE gap.
// ADDR must be wide enough to index every word (2**AW >= NWORDS).
module lde_gate_sequencer #(
    parameter int WIDTH     = 8,
    parameter int NWORDS    = 4,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic C,
    input  logic CLR,
    lde_gate_sequencer_if.slave bus
);

`ifdef LDESEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    // A zero-length phase would merge edges, so each phase lasts at least one cycle.
    localparam int S_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int P_EFF = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
    localparam int H_EFF = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
    localparam int MAX_SP = (S_EFF > P_EFF) ? S_EFF : P_EFF;
    localparam int MAXC   = (MAX_SP > H_EFF) ? MAX_SP : H_EFF;
    localparam int CW     = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, FIN} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  d_q;
    logic [NWORDS-1:0] ge_q;
    logic              g_q, ack_q, busy_q, done_q, err_q, errlat_q;

    logic [NWORDS-1:0] ge_dec_d;
    logic              err_d, xfer_d;
    logic              setup_last, open_last, hold_last;

    // Decode the target word. Out-of-range addresses give an all-zero enable.
    always_comb begin
        ge_dec_d = '0;
        for (int i = 0; i < NWORDS; i++)
            if (bus.ADDR == AW'(i)) ge_dec_d[i] = 1'b1;
        err_d  = ~|ge_dec_d;
        xfer_d = bus.REQ && ack_q && ((state_q == IDLE) || (B2B && state_q == FIN));
    end

    assign setup_last = (cnt_q == CW'(S_EFF - 1));
    assign open_last  = (cnt_q == CW'(P_EFF - 1));
    assign hold_last  = (cnt_q == CW'(H_EFF - 1));

    // Sequencer FSM. Every output is a register, so REQ/ADDR/DIN never reach a pin combinationally.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            d_q      <= '0;
            ge_q     <= '0;
            g_q      <= 1'b1;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            errlat_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    ack_q  <= 1'b1;
                    busy_q <= 1'b0;
                    g_q    <= 1'b1;
                    ge_q   <= '0;
                end
                SETUP: begin
                    if (setup_last) begin
                        cnt_q   <= '0;
                        g_q     <= 1'b0;
                        state_q <= OPEN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OPEN: begin
                    if (open_last) begin
                        cnt_q   <= '0;
                        g_q     <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_last) begin
                        cnt_q   <= '0;
                        ge_q    <= '0;
                        done_q  <= 1'b1;
                        err_q   <= errlat_q;
                        ack_q   <= B2B;
                        state_q <= FIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // An accepted transfer overrides the state's own update. This is
            // the only place where D is loaded.
            if (xfer_d) begin
                d_q      <= bus.DIN;
                ge_q     <= ge_dec_d;
                errlat_q <= err_d;
                g_q      <= 1'b1;
                ack_q    <= 1'b0;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                state_q  <= SETUP;
            end
        end
    end

    assign bus.ACK  = ack_q;
    assign bus.D    = d_q;
    assign bus.G    = g_q;
    assign bus.GE   = ge_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_lde_gate_sequencer.sv
// Directed bench for lde_gate_sequencer.
// dut0 uses the default configuration. dut1 has NWORDS=3, so ADDR=3 is out of range.
// Each DUT drives a behavioural model of its latch bank.
module tb_lde_gate_sequencer;

`ifdef LDESEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic lat_clr = 1'b1;
    always #5 clk = ~clk;

    lde_gate_sequencer_if #(.WIDTH(8), .NWORDS(4), .AW(2)) if0 ();
    lde_gate_sequencer_if #(.WIDTH(8), .NWORDS(3), .AW(2)) if1 ();

    lde_gate_sequencer #(.WIDTH(8), .NWORDS(4), .AW(2), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1))
        dut0 (.C(clk), .CLR(clr), .bus(if0));
    lde_gate_sequencer #(.WIDTH(8), .NWORDS(3), .AW(2), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1))
        dut1 (.C(clk), .CLR(clr), .bus(if1));

    // Behavioural latch banks: a word is transparent while G=0 and its GE=1.
    logic [7:0] lat0 [4];
    logic [7:0] lat1 [3];
    always @(if0.G or if0.GE or if0.D or lat_clr)
        for (int i = 0; i < 4; i++)
            if (lat_clr) lat0[i] = 8'h00;
            else if (!if0.G && if0.GE[i]) lat0[i] = if0.D;
    always @(if1.G or if1.GE or if1.D or lat_clr)
        for (int i = 0; i < 3; i++)
            if (lat_clr) lat1[i] = 8'h00;
            else if (!if1.G && if1.GE[i]) lat1[i] = if1.D;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       req;
        logic [1:0] addr;
        logic [7:0] din;
        logic       ack, g, busy, done, err;
        logic [3:0] ge;
        logic [7:0] d;
    } vec_t;

    vec_t tbl [12];

    // Six rows for one write.
    // Row 0 carries the request. Rows 1-5 show SETUP->OPEN->OPEN->HOLD->FIN->IDLE.
    task automatic fill_write(input int b, input logic [1:0] a, input logic [7:0] dv, input logic [3:0] gev);
        tbl[b+0] = '{req:1'b1, addr:a, din:dv, ack:1'b0, g:1'b1, busy:1'b1, done:1'b0, err:1'b0, ge:gev,  d:dv};
        tbl[b+1] = '{req:1'b0, addr:a, din:dv, ack:1'b0, g:1'b0, busy:1'b1, done:1'b0, err:1'b0, ge:gev,  d:dv};
        tbl[b+2] = '{req:1'b0, addr:a, din:dv, ack:1'b0, g:1'b0, busy:1'b1, done:1'b0, err:1'b0, ge:gev,  d:dv};
        tbl[b+3] = '{req:1'b0, addr:a, din:dv, ack:1'b0, g:1'b1, busy:1'b1, done:1'b0, err:1'b0, ge:gev,  d:dv};
        tbl[b+4] = '{req:1'b0, addr:a, din:dv, ack:B2B,  g:1'b1, busy:1'b1, done:1'b1, err:1'b0, ge:4'h0, d:dv};
        tbl[b+5] = '{req:1'b0, addr:a, din:dv, ack:1'b1, g:1'b1, busy:1'b0, done:1'b0, err:1'b0, ge:4'h0, d:dv};
    endtask

    initial begin
        int glow;
        int done_c;
        logic err_at;
        logic [2:0] ge_any;
        logic [11:0] acc_mask, done_mask, exp_acc, exp_done;

        if0.REQ = 1'b0; if0.ADDR = '0; if0.DIN = '0;
        if1.REQ = 1'b0; if1.ADDR = '0; if1.DIN = '0;

        // Reset held for three cycles.
        #2 clr = 1'b1;
        repeat (3) tick();
        chk("rst_G",    32'(if0.G),    32'h1);
        chk("rst_GE",   32'(if0.GE),   32'h0);
        chk("rst_D",    32'(if0.D),    32'h00);
        chk("rst_BUSY", 32'(if0.BUSY), 32'h0);
        chk("rst_DONE", 32'(if0.DONE), 32'h0);
        chk("rst_ERR",  32'(if0.ERR),  32'h0);
        chk("rst_ACK",  32'(if0.ACK),  32'h0);
        clr = 1'b0;
        lat_clr = 1'b0;
        chk("rel_ACK_pre", 32'(if0.ACK), 32'h0);
        tick();
        chk("rel_ACK",  32'(if0.ACK),  32'h1);
        chk("rel_ACK1", 32'(if1.ACK),  32'h1);
        chk("rel_G",    32'(if0.G),    32'h1);

        // Two back-to-back single writes, table driven.
        fill_write(0, 2'd2, 8'hA5, 4'b0100);
        fill_write(6, 2'd0, 8'h5A, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            if0.REQ  = tbl[i].req;
            if0.ADDR = tbl[i].addr;
            if0.DIN  = tbl[i].din;
            tick();
            chk($sformatf("v%0d_ACK", i),  32'(if0.ACK),  32'(tbl[i].ack));
            chk($sformatf("v%0d_G", i),    32'(if0.G),    32'(tbl[i].g));
            chk($sformatf("v%0d_GE", i),   32'(if0.GE),   32'(tbl[i].ge));
            chk($sformatf("v%0d_BUSY", i), 32'(if0.BUSY), 32'(tbl[i].busy));
            chk($sformatf("v%0d_DONE", i), 32'(if0.DONE), 32'(tbl[i].done));
            chk($sformatf("v%0d_ERR", i),  32'(if0.ERR),  32'(tbl[i].err));
            chk($sformatf("v%0d_D", i),    32'(if0.D),    32'(tbl[i].d));
        end
        if0.REQ = 1'b0;
        chk("lat0_w2", 32'(lat0[2]), 32'hA5);
        chk("lat0_w0", 32'(lat0[0]), 32'h5A);
        chk("lat0_w1", 32'(lat0[1]), 32'h00);
        chk("lat0_w3", 32'(lat0[3]), 32'h00);

        // Out-of-range write on the 3-word instance.
        glow = 0; done_c = -1; err_at = 1'b0; ge_any = '0;
        if1.REQ = 1'b1; if1.ADDR = 2'd3; if1.DIN = 8'h3C;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) if1.REQ = 1'b0;
            ge_any = ge_any | if1.GE;
            if (!if1.G) glow++;
            if (if1.DONE) begin done_c = c; err_at = if1.ERR; end
        end
        chk("oor_GE",     32'(ge_any), 32'h0);
        chk("oor_Glow",   32'(glow),   32'd2);
        chk("oor_DONEc",  32'(done_c), 32'd4);
        chk("oor_ERR",    32'(err_at), 32'h1);
        chk("oor_D",      32'(if1.D),  32'h3C);
        chk("oor_lat",    32'({lat1[0], lat1[1], lat1[2]}), 32'h0);
        chk("oor_idle",   32'({if1.BUSY, if1.ACK}), 32'b01);

        // CLR asserted while G is open: gate closes with no clock edge.
        if0.REQ = 1'b1; if0.ADDR = 2'd1; if0.DIN = 8'h77;
        tick();
        if0.REQ = 1'b0;
        tick();
        chk("clr_Gopen", 32'(if0.G), 32'h0);
        #2 clr = 1'b1;
        #1;
        chk("clr_G",    32'(if0.G),    32'h1);
        chk("clr_GE",   32'(if0.GE),   32'h0);
        chk("clr_BUSY", 32'(if0.BUSY), 32'h0);
        clr = 1'b0;
        chk("clr_ACK_pre", 32'(if0.ACK), 32'h0);
        tick();
        chk("clr_ACK", 32'(if0.ACK), 32'h1);
        chk("clr_D",   32'(if0.D),   32'h00);

        // REQ held high for 12 edges.
        // ACK is sampled before each edge to locate the transfers.
        acc_mask = '0; done_mask = '0;
        if0.REQ = 1'b1; if0.ADDR = 2'd3; if0.DIN = 8'h11;
        for (int c = 0; c < 12; c++) begin
            acc_mask[c] = if0.ACK;
            tick();
            done_mask[c] = if0.DONE;
            if (c == 0) begin
                chk("hold_D1", 32'(if0.D), 32'h11);
                if0.DIN = 8'h22;
            end
        end
        if0.REQ = 1'b0;
        exp_acc  = B2B ? 12'h421 : 12'h041;
        exp_done = B2B ? 12'h210 : 12'h410;
        chk("hold_xfers", 32'(acc_mask),  32'(exp_acc));
        chk("hold_dones", 32'(done_mask), 32'(exp_done));
        chk("hold_D2",    32'(if0.D),     32'h22);
        chk("hold_lat3",  32'(lat0[3]),   32'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
